// File: rtl/network_pkg.sv
// Shared types and default constants for the single-neuron network controller.
package network_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_FRAC_W   = 16;
    localparam int DEF_N_INPUTS = 4;

    // Saturation limits of a DEF_DATA_W-bit signed result
    localparam logic [DEF_DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [DEF_DATA_W-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_ACT  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/neuron_mac.sv
// Combinational signed multiply-add of one input/weight pair into a wide accumulator.
module neuron_mac
    import network_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = 2 * DEF_DATA_W + 2
) (
    input  logic [DATA_W-1:0] in_val,
    input  logic [DATA_W-1:0] weight_val,
    input  logic [ACC_W-1:0]  acc_in,
    output logic [ACC_W-1:0]  acc_out
);

    logic signed [2*DATA_W-1:0] product;

    assign product = $signed(in_val) * $signed(weight_val);
    assign acc_out = acc_in + {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};

endmodule

// File: rtl/network_controller.sv
// Single-neuron controller: input/weight banks, MAC sequencing, saturation and activation.
// Optional ReLU activation is enabled by defining NETWORK_CONTROLLER_RELU_EN.
module network_controller
    import network_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int FRAC_W   = DEF_FRAC_W,
    parameter int N_INPUTS = DEF_N_INPUTS,
    localparam int ADDR_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              weight_we,
    input  logic [ADDR_W-1:0] weight_addr,
    input  logic [DATA_W-1:0] weight_data,
    input  logic              start,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy
);

    localparam int ACC_W = 2 * DATA_W + ADDR_W;

    localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] HI_EXT = {{(ACC_W-DATA_W){1'b0}}, MAX_V};
    localparam logic signed [ACC_W-1:0] LO_EXT = {{(ACC_W-DATA_W){1'b1}}, MIN_V};

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_sum;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               valid_q, valid_d;

    logic [DATA_W-1:0]  in_q [N_INPUTS];
    logic [DATA_W-1:0]  in_d [N_INPUTS];
    logic [DATA_W-1:0]  w_q  [N_INPUTS];
    logic [DATA_W-1:0]  w_d  [N_INPUTS];

    logic               bank_open;
    logic signed [ACC_W-1:0] shifted;
    logic [DATA_W-1:0]  sat_val, act_val;

    // Banks are only writable while idle, so a run always sees a frozen operand set
    assign bank_open = (state_q == ST_IDLE);

    generate
        for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_bank
            assign in_d[gi] = (bank_open && data_we && data_addr == ADDR_W'(gi)) ? data_in : in_q[gi];
            assign w_d[gi]  = (bank_open && weight_we && weight_addr == ADDR_W'(gi)) ? weight_data : w_q[gi];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    in_q[gi] <= '0;
                    w_q[gi]  <= '0;
                end else begin
                    in_q[gi] <= in_d[gi];
                    w_q[gi]  <= w_d[gi];
                end
            end
        end
    endgenerate

    neuron_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .in_val     (in_q[idx_q]),
        .weight_val (w_q[idx_q]),
        .acc_in     (acc_q),
        .acc_out    (acc_sum)
    );

    assign shifted = $signed(acc_q) >>> FRAC_W;

    always_comb begin
        if (shifted > HI_EXT) begin
            sat_val = MAX_V;
        end else if (shifted < LO_EXT) begin
            sat_val = MIN_V;
        end else begin
            sat_val = shifted[DATA_W-1:0];
        end
`ifdef NETWORK_CONTROLLER_RELU_EN
        act_val = sat_val[DATA_W-1] ? '0 : sat_val;
`else
        act_val = sat_val;
`endif
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        valid_d  = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_sum;
                idx_d = idx_q + 1'b1;
                if (idx_q == ADDR_W'(N_INPUTS - 1)) begin
                    state_d = ST_ACT;
                end
            end
            ST_ACT: begin
                result_d = act_val;
                valid_d  = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (result_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign result       = result_q;
    assign result_valid = valid_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_network_controller.sv
// Self-checking bench for network_controller: directed cases plus randomized traffic vs a behavioural model.
module tb_network_controller;

    localparam int DATA_W = 32;
    localparam int N      = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              data_we = 1'b0;
    logic [ADDR_W-1:0] data_addr = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic              weight_we = 1'b0;
    logic [ADDR_W-1:0] weight_addr = '0;
    logic [DATA_W-1:0] weight_data = '0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              result_ready = 1'b0;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;
    bit done_flag = 1'b0;

    network_controller dut (
        .clk          (clk),
        .reset        (reset),
        .data_we      (data_we),
        .data_addr    (data_addr),
        .data_in      (data_in),
        .weight_we    (weight_we),
        .weight_addr  (weight_addr),
        .weight_data  (weight_data),
        .start        (start),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] m_in [N];
    logic [31:0] m_w  [N];
    logic        m_busy, m_valid;
    logic [31:0] m_result, m_pending;
    int          m_cnt;

    function automatic logic [31:0] expect_result();
        logic signed [127:0] s, a, b;
        logic signed [127:0] mx, mn;
        logic [31:0] r;
        s  = 0;
        mx = 128'sh7FFF_FFFF;
        mn = -128'sh8000_0000;
        for (int i = 0; i < N; i++) begin
            a = $signed(m_in[i]);
            b = $signed(m_w[i]);
            s = s + a * b;
        end
        s = s >>> 16;
        if (s > mx)      r = 32'h7FFF_FFFF;
        else if (s < mn) r = 32'h8000_0000;
        else             r = s[31:0];
`ifdef NETWORK_CONTROLLER_RELU_EN
        if (r[31]) r = 32'h0;
`endif
        return r;
    endfunction

    initial begin
        m_busy = 0; m_valid = 0; m_result = 0; m_pending = 0; m_cnt = 0;
        for (int i = 0; i < N; i++) begin m_in[i] = 0; m_w[i] = 0; end
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_busy = 0; m_valid = 0; m_result = 0; m_cnt = 0;
                for (int i = 0; i < N; i++) begin m_in[i] = 0; m_w[i] = 0; end
            end else if (!m_busy) begin
                if (data_we)   m_in[data_addr]  = data_in;
                if (weight_we) m_w[weight_addr] = weight_data;
                if (start) begin
                    m_busy    = 1;
                    m_cnt     = 0;
                    m_pending = expect_result();
                end
            end else if (!m_valid) begin
                m_cnt++;
                if (m_cnt == N + 1) begin
                    m_valid  = 1;
                    m_result = m_pending;
                end
            end else if (result_ready) begin
                m_valid = 0;
                m_busy  = 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (done_flag) break;
            check("busy", 64'(busy), 64'(m_busy));
            check("result_valid", 64'(result_valid), 64'(m_valid));
            check("result", 64'(result), 64'(m_result));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load_all(input logic [31:0] iv, input logic [31:0] wv);
        for (int i = 0; i < N; i++) begin
            data_we = 1; data_addr = ADDR_W'(i); data_in = iv;
            weight_we = 1; weight_addr = ADDR_W'(i); weight_data = wv;
            step();
        end
        data_we = 0; weight_we = 0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!result_valid && edges < 40) begin
            step();
            edges++;
        end
        if (!result_valid) check("wait_valid_timeout", 64'(result_valid), 64'd1);
    endtask

    task automatic run(input string name, input logic [31:0] exp_res);
        int e;
        start = 1;
        step();
        start = 0;
        wait_valid(e);
        check({name, "_latency"}, 64'(e), 64'(N + 1));
        check({name, "_result"}, 64'(result), 64'(exp_res));
    endtask

    task automatic accept();
        result_ready = 1;
        step();
        result_ready = 0;
        check("accept_valid", 64'(result_valid), 64'd0);
        check("accept_busy", 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] rand_val();
        logic [31:0] r;
        int k;
        r = $urandom();
        case ($urandom_range(0, 3))
            0: return r;
            1: begin k = int'($urandom_range(0, 8)) - 4; return 32'(k) << 16; end
            2: return ($urandom_range(0, 1) != 0) ? 32'h7FFF_0000 : 32'h8000_0000;
            default: return {{12{r[19]}}, r[19:0]};
        endcase
    endfunction

    initial begin
        int e;
        repeat (3) step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(result_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        reset = 1;
        step();

        load_all(32'h0001_0000, 32'h0000_8000);
        run("half", 32'h0002_0000);
        accept();

        load_all(32'h0001_0000, 32'hFFFF_0000);
`ifdef NETWORK_CONTROLLER_RELU_EN
        run("neg", 32'h0000_0000);
`else
        run("neg", 32'hFFFC_0000);
`endif
        accept();

        load_all(32'h7FFF_0000, 32'h7FFF_0000);
        run("sat_hi", 32'h7FFF_FFFF);
        accept();

        load_all(32'h7FFF_0000, 32'h8000_0000);
`ifdef NETWORK_CONTROLLER_RELU_EN
        run("sat_lo", 32'h0000_0000);
`else
        run("sat_lo", 32'h8000_0000);
`endif
        accept();

        // Start and write pulsed mid-run must be ignored
        load_all(32'h0001_0000, 32'h0000_8000);
        start = 1;
        step();
        start = 0;
        step();
        start = 1; data_we = 1; data_addr = 0; data_in = 32'h0005_0000;
        step();
        start = 0; data_we = 0;
        wait_valid(e);
        check("midrun_result", 64'(result), 64'h0002_0000);
        accept();
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_second_run", 64'(busy), 64'd0);
        end
        run("slot0_kept", 32'h0002_0000);

        // Consumer stall
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_valid", 64'(result_valid), 64'd1);
            check("stall_result", 64'(result), 64'h0002_0000);
        end
        accept();

        // Reset in the middle of a run
        start = 1;
        step();
        start = 0;
        repeat (3) step();
        reset = 0;
        #1;
        check("abort_valid", 64'(result_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        step();
        step();
        reset = 1;
        step();
        run("cleared_slots", 32'h0000_0000);
        accept();

        // Randomized traffic, checked by the per-cycle compare process
        for (int c = 0; c < 600; c++) begin
            data_we      = ($urandom_range(0, 2) == 0);
            data_addr    = ADDR_W'($urandom_range(0, N - 1));
            data_in      = rand_val();
            weight_we    = ($urandom_range(0, 2) == 0);
            weight_addr  = ADDR_W'($urandom_range(0, N - 1));
            weight_data  = rand_val();
            start        = ($urandom_range(0, 4) == 0);
            result_ready = ($urandom_range(0, 2) == 0);
            reset        = ($urandom_range(0, 149) != 0);
            step();
        end
        reset = 1; data_we = 0; weight_we = 0; start = 0; result_ready = 0;
        step();
        step();

        done_flag = 1'b1;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
